// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin arbiter/sequencer sharing one W-bit add/subtract
// unit between N_REQ requesters. Each granted request runs IDLE -> EXEC -> RESP.
// The shared unit sees only registered operands. Its result is captured into a
// tagged response register that is held until the consumer takes it.
// Optional build macro ADDSUB_ARB_OVERLAP_EN: when it is defined, arbitration
// also runs in RESP while rsp_ready is high. The next grant then overlaps
// response retirement, giving a 2-cycle issue interval instead of 3.
module addsub_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 16,
    parameter int IDW   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*W-1:0]   req_a,
    input  logic [N_REQ*W-1:0]   req_b,
    input  logic [2*N_REQ-1:0]   req_op,
    output logic [W-1:0]         au_in1,
    output logic [W-1:0]         au_in2,
    output logic                 au_cin1,
    output logic                 au_cin2,
    input  logic [W-1:0]         au_out,
    input  logic                 au_co,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [W-1:0]         rsp_data,
    output logic                 rsp_co
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [N_REQ-1:0] ONE_N = {{(N_REQ-1){1'b0}}, 1'b1};

    logic [1:0]       state_reg, state_next;
    logic [IDW-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [W-1:0]     a_reg, b_reg;
    logic [1:0]       op_reg;
    logic [IDW-1:0]   id_reg;
    logic [W-1:0]     rsp_data_reg;
    logic             rsp_co_reg;
    logic [IDW-1:0]   rsp_id_reg;

    logic             arb_en;
    logic             accept;
    logic [N_REQ-1:0] hi_mask, masked, pick_src, grant_oh;
    logic [IDW-1:0]   grant_idx;
    logic [W-1:0]     sel_a, sel_b;
    logic [1:0]       sel_op;

`ifdef ADDSUB_ARB_OVERLAP_EN
    // Arbitrate in IDLE, and also in RESP on the cycle the response retires
    assign arb_en = (state_reg == IDLE) || ((state_reg == RESP) && rsp_ready);
`else
    // Arbitrate only in IDLE
    assign arb_en = (state_reg == IDLE);
`endif

    // Round-robin pick: lowest valid index at or above rr_ptr, else lowest valid overall
    assign hi_mask  = ~((ONE_N << rr_ptr_reg) - ONE_N);
    assign masked   = req_valid & hi_mask;
    assign pick_src = (|masked) ? masked : req_valid;
    assign grant_oh = pick_src & (~pick_src + ONE_N);

    // One-hot grant to index and operand mux, built as an OR chain per requester
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_sel
        logic [IDW-1:0] idx_prev, idx_acc;
        logic [W-1:0]   a_prev, a_acc, b_prev, b_acc;
        logic [1:0]     op_prev, op_acc;
        if (gi == 0) begin : g_first
            assign idx_prev = '0;
            assign a_prev   = '0;
            assign b_prev   = '0;
            assign op_prev  = '0;
        end else begin : g_rest
            assign idx_prev = g_sel[gi-1].idx_acc;
            assign a_prev   = g_sel[gi-1].a_acc;
            assign b_prev   = g_sel[gi-1].b_acc;
            assign op_prev  = g_sel[gi-1].op_acc;
        end
        assign idx_acc = idx_prev | (grant_oh[gi] ? IDW'(gi) : '0);
        assign a_acc   = a_prev | (grant_oh[gi] ? req_a[gi*W +: W] : '0);
        assign b_acc   = b_prev | (grant_oh[gi] ? req_b[gi*W +: W] : '0);
        assign op_acc  = op_prev | (grant_oh[gi] ? req_op[gi*2 +: 2] : '0);
    end

    assign grant_idx = g_sel[N_REQ-1].idx_acc;
    assign sel_a     = g_sel[N_REQ-1].a_acc;
    assign sel_b     = g_sel[N_REQ-1].b_acc;
    assign sel_op    = g_sel[N_REQ-1].op_acc;

    // The granted requester's ready equals its valid, so any valid means a handshake
    assign accept    = arb_en && (|req_valid);
    // Ready is forced low while reset is held, even though the state already reads IDLE
    assign req_ready = grant_oh & {N_REQ{arb_en & rst_n}};

    assign rr_ptr_next = (grant_idx == IDW'(N_REQ-1)) ? '0 : grant_idx + IDW'(1);

    // Next-state logic for the IDLE/EXEC/RESP sequencer
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = accept ? EXEC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register and round-robin pointer, which advances only on a handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) rr_ptr_reg <= rr_ptr_next;
        end
    end

    // Latch the granted request's operands, op and index on the accept edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg  <= '0;
            b_reg  <= '0;
            op_reg <= '0;
            id_reg <= '0;
        end else if (accept) begin
            a_reg  <= sel_a;
            b_reg  <= sel_b;
            op_reg <= sel_op;
            id_reg <= grant_idx;
        end
    end

    // Capture the shared unit's result at the end of EXEC and hold it through RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_reg <= '0;
            rsp_co_reg   <= 1'b0;
            rsp_id_reg   <= '0;
        end else if (state_reg == EXEC) begin
            rsp_data_reg <= au_out;
            rsp_co_reg   <= au_co;
            rsp_id_reg   <= id_reg;
        end
    end

    // Shared unit inputs come only from registers and read as zero outside EXEC
    assign au_in1  = (state_reg == EXEC) ? a_reg : '0;
    assign au_in2  = (state_reg == EXEC) ? b_reg : '0;
    assign au_cin1 = (state_reg == EXEC) && op_reg[1];
    assign au_cin2 = (state_reg == EXEC) && op_reg[0];

    assign rsp_valid = (state_reg == RESP);
    assign rsp_data  = rsp_data_reg;
    assign rsp_co    = rsp_co_reg;
    assign rsp_id    = rsp_id_reg;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Testbench for addsub_arbiter: table vectors, directed multi-cycle sequences
// and a randomized run against a behavioural round-robin/arithmetic model.
module tb_addsub_arbiter;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int IDW = 2;
`ifdef ADDSUB_ARB_OVERLAP_EN
    localparam int EXP_IV = 2;
`else
    localparam int EXP_IV = 3;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0]   req_valid, req_ready;
    logic [N*W-1:0] req_a, req_b;
    logic [2*N-1:0] req_op;
    logic [W-1:0]   au_in1, au_in2, au_out;
    logic           au_cin1, au_cin2, au_co;
    logic           rsp_valid, rsp_ready;
    logic [IDW-1:0] rsp_id;
    logic [W-1:0]   rsp_data;
    logic           rsp_co;
    logic [W:0]     au_sum;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    addsub_arbiter #(.N_REQ(N), .W(W), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .au_in1(au_in1), .au_in2(au_in2), .au_cin1(au_cin1), .au_cin2(au_cin2),
        .au_out(au_out), .au_co(au_co),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_co(rsp_co)
    );

    // Shared add/subtract unit attached to the arbiter
    always_comb begin
        case ({au_cin1, au_cin2})
            2'b11:   au_sum = {1'b0, au_in1} + {1'b0, ~au_in2} + (W+1)'(1);
            2'b10:   au_sum = {1'b0, au_in1} + {1'b0, au_in2} + (W+1)'(1);
            default: au_sum = {1'b0, au_in1} + {1'b0, ~au_in2};
        endcase
    end
    assign au_out = au_sum[W-1:0];
    assign au_co  = au_sum[W];

    // Reference arithmetic from plain integer rules: returns {co, data}
    function automatic logic [W:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [1:0] op);
        int unsigned ai = a;
        int unsigned bi = b;
        int unsigned m = 1 << W;
        int unsigned d;
        logic co;
        case (op)
            2'b11:   begin d = (ai + m - bi) % m;     co = (ai >= bi); end
            2'b10:   begin d = (ai + bi + 1) % m;     co = ((ai + bi + 1) >= m); end
            default: begin d = (ai + m - bi - 1) % m; co = (ai > bi); end
        endcase
        return {co, d[W-1:0]};
    endfunction

    // Round-robin rule: first valid index at or after p, with wrap
    function automatic int first_from(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] oh = '0;
        if (g >= 0) oh[g] = 1'b1;
        return oh;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [1:0] op);
        req_a[i*W +: W]  = a;
        req_b[i*W +: W]  = b;
        req_op[2*i +: 2] = op;
        req_valid[i]     = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        check("rst_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_rsp(input int maxc, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < maxc && !ok; c++) begin
            @(negedge clk);
            #1;
            if (rsp_valid) ok = 1'b1;
        end
    endtask

    typedef struct {
        int         id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0] op;
        logic [W-1:0] exp_data;
        logic       exp_co;
    } vec_t;

    typedef struct {
        int       id;
        logic [W:0] res;
    } exp_t;

    vec_t tbl[8];
    exp_t exp_q[$];

    initial begin
        bit ok;
        int n;
        int times[4];
        int ids[4];
        int model_ptr;
        logic [N-1:0] hs, hs_prev;
        exp_t e;

        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        int n;
        int times[4];
        int ids[4];
        int model_ptr;
        logic [N-1:0] hs, hs_prev;
        exp_t e;

        tbl[0] = '{0, 16'h0005, 16'h0003, 2'b11, 16'h0002, 1'b1};
        tbl[1] = '{1, 16'hFFFF, 16'h0001, 2'b10, 16'h0001, 1'b1};
        tbl[2] = '{2, 16'hFFFF, 16'h0001, 2'b00, 16'hFFFD, 1'b1};
        tbl[3] = '{3, 16'hFFFF, 16'h0001, 2'b01, 16'hFFFD, 1'b1};
        tbl[4] = '{1, 16'h0003, 16'h0005, 2'b11, 16'hFFFE, 1'b0};
        tbl[5] = '{2, 16'h0000, 16'h0000, 2'b00, 16'hFFFF, 1'b0};
        tbl[6] = '{0, 16'h1234, 16'h1234, 2'b11, 16'h0000, 1'b1};
        tbl[7] = '{3, 16'h8000, 16'h8000, 2'b10, 16'h0001, 1'b1};

        req_valid = '0; req_a = '0; req_b = '0; req_op = '1; rsp_ready = 1'b0;

        // Reset state with every requester valid
        repeat (2) @(negedge clk);
        req_valid = '1;
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid0", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_co", rsp_co, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_au_in1", au_in1, 0);
        check("rst_au_in2", au_in2, 0);
        check("rst_au_cin", {au_cin1, au_cin2}, 0);
        @(negedge clk);
        req_valid = '0;
        rsp_ready = 1'b1;
        rst_n = 1'b1;

        // Table-driven single transactions
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            set_req(tbl[t].id, tbl[t].a, tbl[t].b, tbl[t].op);
            #1;
            check("tbl_ready", req_ready, onehot(tbl[t].id));
            @(negedge clk);
            req_valid = '0;
            #1;
            check("tbl_exec_ready", req_ready, 0);
            check("tbl_exec_in1", au_in1, tbl[t].a);
            check("tbl_exec_in2", au_in2, tbl[t].b);
            check("tbl_exec_op", {au_cin1, au_cin2}, tbl[t].op);
            check("tbl_exec_rsp_valid", rsp_valid, 0);
            @(negedge clk);
            #1;
            check("tbl_rsp_valid", rsp_valid, 1);
            check("tbl_rsp_id", rsp_id, tbl[t].id);
            check("tbl_rsp_data", rsp_data, tbl[t].exp_data);
            check("tbl_rsp_co", rsp_co, tbl[t].exp_co);
            $display("txn tbl %0d id=%0d data=%h co=%b", t, rsp_id, rsp_data, rsp_co);
            @(negedge clk);
            #1;
            check("tbl_retired", rsp_valid, 0);
        end

        // Grant moves on in the same cycle when a valid drops without a handshake
        do_reset();
        @(negedge clk);
        set_req(1, 16'h00AA, 16'h0011, 2'b10);
        set_req(2, 16'h0100, 16'h0001, 2'b11);
        #1;
        check("drop_ready_before", req_ready, 4'b0010);
        req_valid[1] = 1'b0;
        #1;
        check("drop_ready_after", req_ready, 4'b0100);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(6, ok);
        check("drop_rsp_seen", ok, 1);
        check("drop_rsp_id", rsp_id, 2);
        check("drop_rsp_data", rsp_data, 16'h00FF);
        $display("txn drop id=%0d data=%h co=%b", rsp_id, rsp_data, rsp_co);
        @(negedge clk);

        // Reset pulse during EXEC discards the request and clears rr_ptr
        @(negedge clk);
        set_req(2, 16'h0F0F, 16'h0101, 2'b10);
        #1;
        check("rexec_ready", req_ready, 4'b0100);
        @(negedge clk);
        req_valid = '0;
        #1;
        check("rexec_in1", au_in1, 16'h0F0F);
        rst_n = 1'b0;
        set_req(1, 16'h0007, 16'h0002, 2'b11);
        set_req(3, 16'h0009, 16'h0001, 2'b11);
        #1;
        check("rexec_req_ready", req_ready, 0);
        check("rexec_rsp_valid", rsp_valid, 0);
        check("rexec_rsp_data", rsp_data, 0);
        check("rexec_rsp_id", rsp_id, 0);
        check("rexec_au_in1", au_in1, 0);
        check("rexec_au_in2", au_in2, 0);
        check("rexec_au_cin", {au_cin1, au_cin2}, 0);
        @(negedge clk);
        #1;
        check("rexec_rsp_valid2", rsp_valid, 0);
        rst_n = 1'b1;
        #1;
        check("rexec_lowest_grant", req_ready, 4'b0010);
        @(negedge clk);
        req_valid = '0;
        #1;
        check("rexec_no_rsp", rsp_valid, 0);
        @(negedge clk);
        #1;
        check("rexec_rsp_valid3", rsp_valid, 1);
        check("rexec_rsp_id2", rsp_id, 1);
        check("rexec_rsp_data2", rsp_data, 16'h0005);
        $display("txn rexec id=%0d data=%h co=%b", rsp_id, rsp_data, rsp_co);
        @(negedge clk);

        // Round-robin order with all four requesters valid
        do_reset();
        @(negedge clk);
        for (int i = 0; i < N; i++) set_req(i, W'(16'h0010 + 16'h0100 * i), W'(i), 2'b10);
        n = 0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            @(negedge clk);
            #1;
            if (rsp_valid) begin
                check("rr_id", rsp_id, n % N);
                check("rr_data", rsp_data, ref_result(W'(16'h0010 + 16'h0100 * (n % N)), W'(n % N), 2'b10));
                $display("txn rr id=%0d data=%h co=%b", rsp_id, rsp_data, rsp_co);
                n++;
            end
        end
        check("rr_count", n, 5);
        req_valid = '0;
        repeat (5) @(negedge clk);

        // Backpressure: response held for 5 stalled cycles, then retires
        @(negedge clk);
        rsp_ready = 1'b0;
        set_req(0, 16'h1000, 16'h0001, 2'b11);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(6, ok);
        check("bp_rsp_seen", ok, 1);
        set_req(2, 16'h0002, 16'h0002, 2'b10);
        for (int j = 0; j < 5; j++) begin
            if (j > 0) begin
                @(negedge clk);
                #1;
            end
            check("bp_valid", rsp_valid, 1);
            check("bp_data", rsp_data, 16'h0FFF);
            check("bp_co", rsp_co, 1);
            check("bp_req_ready", req_ready, 0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = '0;
        #1;
        check("bp_still_valid", rsp_valid, 1);
        $display("txn bp id=%0d data=%h co=%b", rsp_id, rsp_data, rsp_co);
        @(negedge clk);
        #1;
        check("bp_retired", rsp_valid, 0);

        // Issue interval with two requesters constantly valid
        do_reset();
        @(negedge clk);
        set_req(0, 16'h0001, 16'h0001, 2'b10);
        set_req(1, 16'h0002, 16'h0001, 2'b10);
        n = 0;
        for (int c = 0; c < 30 && n < 4; c++) begin
            @(negedge clk);
            #1;
            if (rsp_valid) begin
                times[n] = cyc;
                ids[n] = rsp_id;
                n++;
            end
        end
        check("iv_count", n, 4);
        for (int k = 1; k < n; k++) begin
            check("iv_interval", times[k] - times[k-1], EXP_IV);
            check("iv_id", ids[k], k % 2);
        end
        req_valid = '0;
        repeat (5) @(negedge clk);

        // Randomized traffic against the behavioural model
        do_reset();
        model_ptr = 0;
        hs_prev = '0;
        for (int c = 0; c < 560; c++) begin
            @(negedge clk);
            req_valid = req_valid & ~hs_prev;
            if (c < 500) begin
                for (int i = 0; i < N; i++)
                    if (!req_valid[i] && $urandom_range(0, 2) == 0)
                        set_req(i, W'($urandom), W'($urandom), 2'($urandom));
                rsp_ready = ($urandom_range(0, 9) < 7);
            end else begin
                rsp_ready = 1'b1;
            end
            #1;
            check("rnd_ready_onehot", ($countones(req_ready) <= 1), 1);
            if (rsp_valid && rsp_ready) begin
                check("rnd_q_size", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("rnd_rsp_id", rsp_id, e.id);
                    check("rnd_rsp_data", rsp_data, e.res[W-1:0]);
                    check("rnd_rsp_co", rsp_co, e.res[W]);
                    $display("txn rnd id=%0d data=%h co=%b", rsp_id, rsp_data, rsp_co);
                end
            end
            hs = req_valid & req_ready;
            if (hs != '0) begin
                int g;
                g = first_from(req_valid, model_ptr);
                check("rnd_grant", hs, onehot(g));
                if (g >= 0) begin
                    e.id = g;
                    e.res = ref_result(req_a[g*W +: W], req_b[g*W +: W], req_op[2*g +: 2]);
                    exp_q.push_back(e);
                    model_ptr = (g + 1) % N;
                end
            end
            hs_prev = hs;
        end
        check("rnd_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Round-robin arbiter and sequencer that shares one 16-bit add/subtract unit between `N_REQ` requesters. Each requester presents operands and a 2-bit op over a valid/ready handshake. The block grants one requester at a time and drives the shared unit's `in1`/`in2`/`cin1`/`cin2` from registered operands. It captures `out`/`co` and returns the result on a single tagged response channel with backpressure. It sits between the requesting datapath blocks and the single shared adder instance.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `W`, 16: operand width; must equal the shared unit width.
- `IDW`, 2: requester-ID width, ≥ ceil(log2(N_REQ)).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in N_REQ: per-requester request valid.
- `req_ready` out N_REQ: per-requester accept; at most one bit high.
- `req_a` in N_REQ*W: packed operand A; requester i at [i*W +: W].
- `req_b` in N_REQ*W: packed operand B.
- `req_op` in 2*N_REQ: packed {cin1,cin2} per requester.
- `au_in1` out W: to shared unit `in1`.
- `au_in2` out W: to shared unit `in2`.
- `au_cin1` out 1: to shared unit `cin1`.
- `au_cin2` out 1: to shared unit `cin2`.
- `au_out` in W: from shared unit `out`; combinational.
- `au_co` in 1: from shared unit `co`.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response consumer ready.
- `rsp_id` out IDW: index of the requester that owns the response.
- `rsp_data` out W: captured result.
- `rsp_co` out 1: captured carry-out.

## Operation
- Shared unit semantics, op {cin1,cin2}:
  - 2'b11 gives A−B (mod 2^W).
  - 2'b10 gives A+B+1.
  - 2'b0x gives A+~B, i.e. A−B−1.
  - The arbiter passes op through unmodified and does no arithmetic itself.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant goes to the first requester with `req_valid` set, searching from `rr_ptr` upward with wrap.
  - `req_ready[g]`=1 combinationally for the granted index only.
  - On the clock edge with `req_valid[g]` and `req_ready[g]` both high: latch A, B, op and g; then `rr_ptr` ← (g+1) mod N_REQ; state → EXEC.
  - With no valid request, remain in IDLE and leave `rr_ptr` unchanged.
- EXEC:
  - `au_*` driven from the latched registers.
  - At the next edge: `rsp_data`←`au_out`, `rsp_co`←`au_co`, `rsp_id`←g; state → RESP.
- RESP:
  - `rsp_valid`=1; `rsp_data`, `rsp_co` and `rsp_id` are held stable until handshake.
  - On the edge with `rsp_valid` and `rsp_ready` both high: state → IDLE.
  - `req_ready` is all-zero in EXEC and RESP, except as allowed under Configuration.
- `au_*` outputs are 0 in IDLE. No combinational path from `au_out` to any output.
- A requester may drop `req_valid` without a handshake. The grant then moves on in the same cycle and there is no lock-in.
- Reset mid-operation: in-flight request discarded; all state cleared immediately.

## Timing
- Reset values:
  - `req_ready`=0 while `rst_n` is low.
  - `rsp_valid`=0, `rsp_data`=0, `rsp_co`=0, `rsp_id`=0.
  - `au_in1`=`au_in2`=0, `au_cin1`=`au_cin2`=0.
  - `rr_ptr`=0, state=IDLE.
- Accept at edge T. EXEC spans T→T+1. `rsp_valid` is high from T+1.
- Minimum issue interval is 3 cycles, reached when `rsp_ready` is held high.
- `rsp_ready` stalls hold RESP indefinitely; the outputs do not change during the stall.

## Configuration
- `ADDSUB_ARB_OVERLAP_EN`
  - Defined: in RESP with `rsp_ready`=1, arbitration runs as in IDLE. A new grant is handshaken on the same edge the response retires, and state goes RESP → EXEC directly. Minimum issue interval becomes 2 cycles.
  - Undefined: RESP always returns to IDLE before the next grant; interval is 3 cycles.

## Test plan
- Single request, reset then requester 0 sends A=16'h0005, B=16'h0003, op=2'b11, `rsp_ready`=1:
  - Accept on the first edge.
  - Response next cycle: `rsp_id`=0, `rsp_data`=16'h0002, `rsp_co`=1.
- All four requesters valid continuously, each with a distinct A:
  - Grants go in order 0,1,2,3,0.
  - `rsp_id` follows the same sequence; no requester is granted twice before the others.
- Backpressure: `rsp_ready`=0 for 5 cycles after `rsp_valid`:
  - `rsp_valid` and `rsp_data` are held constant.
  - `req_ready`=0 throughout.
  - Retires on the first cycle `rsp_ready`=1.
- Op coverage, with A=16'hFFFF, B=16'h0001:
  - op 2'b10 gives `rsp_data`=16'h0001, `rsp_co`=1.
  - op 2'b00 gives `rsp_data`=16'hFFFD, `rsp_co`=1.
- Reset pulse during EXEC:
  - `rsp_valid` never asserts.
  - All outputs are 0 while `rst_n` is low.
  - The next request to arrive is granted to the lowest valid index (`rr_ptr`=0).
- With `ADDSUB_ARB_OVERLAP_EN` defined, two requesters constantly valid and `rsp_ready`=1:
  - Consecutive `rsp_valid` pulses are exactly 2 cycles apart.
  - Without the macro they are 3 cycles apart.
